// File: rtl/sys_bus_test.sv
// sys_bus_test: single-master system-bus controller with an internal register memory.
//
// A transaction is an ALE pulse (IDLE->ADDR), a command cycle with a read or write strobe and
// the address (ADDR->READ/WRITE), a one-cycle data phase, and a one-cycle DONE acknowledge.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   ale_en         address latch enable, opens a transaction from IDLE
//   bus_read_en    read command strobe (ADDR only)
//   bus_write_en   write command strobe (ADDR only, wins over read)
//   addr_input     transaction address, captured in the command cycle
//   data_write     write data, captured in the WRITE cycle
//   data_read      registered read data, held until the next READ or reset
//   state_now      registered one-hot FSM state
//   state_nxt      combinational next state (includes the effect of rst)
//   bus_ready      high while in DONE
//   bus_addr       latched transaction address
//   io_write_en    high while in WRITE
//   io_read_en     high while in READ
//   bus_data_write last written data, registered
//
// Optional feature macro: BUS_TIMEOUT_EN. When defined, ADDR falls back to IDLE after
// TIMEOUT_CYCLES consecutive cycles without a command strobe. When undefined, ADDR waits forever.

module sys_bus_test #(
   parameter int unsigned MEM_WIDTH      = 8,
   parameter int unsigned MEM_DEPTH      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ale_en,
   input  logic                 bus_read_en,
   input  logic                 bus_write_en,
   input  logic [MEM_DEPTH-1:0] addr_input,
   input  logic [MEM_WIDTH-1:0] data_write,
   output logic [MEM_WIDTH-1:0] data_read,
   output logic [4:0]           state_now,
   output logic [4:0]           state_nxt,
   output logic                 bus_ready,
   output logic [MEM_DEPTH-1:0] bus_addr,
   output logic                 io_write_en,
   output logic                 io_read_en,
   output logic [MEM_WIDTH-1:0] bus_data_write
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [4:0] {
      StIdle  = 5'b00001,
      StAddr  = 5'b00010,
      StWrite = 5'b00100,
      StRead  = 5'b01000,
      StDone  = 5'b10000
   } state_e;

   state_e               state_q, state_d;
   logic [MEM_WIDTH-1:0] data_read_q, data_read_d;
   logic [MEM_DEPTH-1:0] bus_addr_q, bus_addr_d;
   logic [MEM_WIDTH-1:0] bus_data_write_q, bus_data_write_d;
   logic                 mem_we;

   // Storage is deliberately left out of reset.
   logic [MEM_WIDTH-1:0] mem_q [2**MEM_DEPTH];

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d          = state_q;
      data_read_d      = data_read_q;
      bus_addr_d       = bus_addr_q;
      bus_data_write_d = bus_data_write_q;
      mem_we           = 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_d            = '0;
`endif
      unique case (state_q)
         StIdle: begin
            if (ale_en) state_d = StAddr;
         end
         StAddr: begin
            if (bus_write_en) begin
               state_d    = StWrite;
               bus_addr_d = addr_input;
            end else if (bus_read_en) begin
               state_d    = StRead;
               bus_addr_d = addr_input;
            end else begin
`ifdef BUS_TIMEOUT_EN
               // cnt_q counts idle ADDR cycles already spent; the last allowed one exits.
               if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
         end
         StWrite: begin
            mem_we           = ~rst;
            bus_data_write_d = data_write;
            state_d          = StDone;
         end
         StRead: begin
            data_read_d = mem_q[bus_addr_q];
            state_d     = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         data_read_q      <= '0;
         bus_addr_q       <= '0;
         bus_data_write_q <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt_q            <= '0;
`endif
      end else begin
         state_q          <= state_d;
         data_read_q      <= data_read_d;
         bus_addr_q       <= bus_addr_d;
         bus_data_write_q <= bus_data_write_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q            <= cnt_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[bus_addr_q] <= data_write;
   end

   assign state_now      = state_q;
   assign state_nxt      = rst ? StIdle : state_d;
   assign data_read      = data_read_q;
   assign bus_addr       = bus_addr_q;
   assign bus_data_write = bus_data_write_q;
   assign io_write_en    = (state_q == StWrite);
   assign io_read_en     = (state_q == StRead);
   assign bus_ready      = (state_q == StDone);

endmodule

// File: tb/tb_sys_bus_test.sv
// Directed table-driven bench for sys_bus_test. Each record is the input set for one clock
// edge and the expected outputs after that edge.

module tb_sys_bus_test;

   localparam logic [4:0] IDLE  = 5'b00001;
   localparam logic [4:0] ADDR  = 5'b00010;
   localparam logic [4:0] WRITE = 5'b00100;
   localparam logic [4:0] READ  = 5'b01000;
   localparam logic [4:0] DONE  = 5'b10000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ale_en = 1'b0, bus_read_en = 1'b0, bus_write_en = 1'b0;
   logic [7:0] addr_input = '0, data_write = '0;
   logic [7:0] data_read, bus_addr, bus_data_write;
   logic [4:0] state_now, state_nxt;
   logic       bus_ready, io_write_en, io_read_en;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sys_bus_test #(
      .MEM_WIDTH(8),
      .MEM_DEPTH(8),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ale_en(ale_en),
      .bus_read_en(bus_read_en),
      .bus_write_en(bus_write_en),
      .addr_input(addr_input),
      .data_write(data_write),
      .data_read(data_read),
      .state_now(state_now),
      .state_nxt(state_nxt),
      .bus_ready(bus_ready),
      .bus_addr(bus_addr),
      .io_write_en(io_write_en),
      .io_read_en(io_read_en),
      .bus_data_write(bus_data_write)
   );

   typedef struct {
      logic       rst, ale, rd, wr;
      logic [7:0] addr, wdata;
      logic [4:0] st;
      logic [7:0] dr, ba, bdw;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t v(logic r, logic a, logic rd, logic wr, logic [7:0] ad,
                              logic [7:0] wd, logic [4:0] st, logic [7:0] dr, logic [7:0] ba,
                              logic [7:0] bdw);
      vec_t x;
      x.rst = r; x.ale = a; x.rd = rd; x.wr = wr; x.addr = ad; x.wdata = wd;
      x.st = st; x.dr = dr; x.ba = ba; x.bdw = bdw;
      return x;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
   endtask

   // Drive at negedge, check state_nxt before the edge, check outputs 1 time unit after it.
   task automatic step(input int idx, input vec_t x, input bit full);
      @(negedge clk);
      rst = x.rst; ale_en = x.ale; bus_read_en = x.rd; bus_write_en = x.wr;
      addr_input = x.addr; data_write = x.wdata;
      #1;
      chk("state_nxt", idx, 32'(state_nxt), 32'(x.st));
      @(posedge clk);
      #1;
      chk("state_now", idx, 32'(state_now), 32'(x.st));
      chk("bus_ready", idx, 32'(bus_ready), 32'(x.st == DONE));
      chk("io_write_en", idx, 32'(io_write_en), 32'(x.st == WRITE));
      chk("io_read_en", idx, 32'(io_read_en), 32'(x.st == READ));
      if (full) begin
         chk("data_read", idx, 32'(data_read), 32'(x.dr));
         chk("bus_addr", idx, 32'(bus_addr), 32'(x.ba));
         chk("bus_data_write", idx, 32'(bus_data_write), 32'(x.bdw));
      end
   endtask

   initial begin
      //              rst ale rd wr addr   wdata  state  dr     ba     bdw
      vq.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'h00, 8'h00, 8'h00)); // reset
      // write 0xFF to 0x04
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, 8'h00, 8'h00));
      vq.push_back(v(0, 0, 0, 1, 8'h04, 8'h00, WRITE, 8'h00, 8'h04, 8'h00));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'hFF, DONE,  8'h00, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'h00, 8'h04, 8'hFF));
      // read back 0x04
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 1, 0, 8'h04, 8'h00, READ,  8'h00, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, DONE,  8'hFF, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hFF, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hFF, 8'h04, 8'hFF));
      // both strobes: write wins, then immediate read-back
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, 8'h04, 8'hFF));
      vq.push_back(v(0, 0, 1, 1, 8'h10, 8'hA5, WRITE, 8'hFF, 8'h10, 8'hFF));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'hA5, DONE,  8'hFF, 8'h10, 8'hA5));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hFF, 8'h10, 8'hA5));
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, 8'h10, 8'hA5));
      vq.push_back(v(0, 0, 1, 0, 8'h10, 8'h00, READ,  8'hFF, 8'h10, 8'hA5));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, DONE,  8'hA5, 8'h10, 8'hA5));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hA5, 8'h10, 8'hA5));
      // strobes without ALE are ignored in IDLE
      vq.push_back(v(0, 0, 0, 1, 8'h04, 8'h00, IDLE,  8'hA5, 8'h10, 8'hA5));
      vq.push_back(v(0, 0, 1, 0, 8'h04, 8'h00, IDLE,  8'hA5, 8'h10, 8'hA5));
      // ALE held high through a read of 0x04 (must still be 0xFF)
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'hA5, 8'h10, 8'hA5));
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'hA5, 8'h10, 8'hA5));
      vq.push_back(v(0, 1, 1, 0, 8'h04, 8'h00, READ,  8'hA5, 8'h04, 8'hA5));
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, DONE,  8'hFF, 8'h04, 8'hA5));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hFF, 8'h04, 8'hA5));
      // reset at the WRITE edge: no commit to 0x04
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'hFF, 8'h04, 8'hA5));
      vq.push_back(v(0, 0, 0, 1, 8'h04, 8'h11, WRITE, 8'hFF, 8'h04, 8'hA5));
      vq.push_back(v(1, 0, 0, 0, 8'h00, 8'h11, IDLE,  8'h00, 8'h00, 8'h00));
      vq.push_back(v(0, 1, 0, 0, 8'h00, 8'h00, ADDR,  8'h00, 8'h00, 8'h00));
      vq.push_back(v(0, 0, 1, 0, 8'h04, 8'h00, READ,  8'h00, 8'h04, 8'h00));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, DONE,  8'hFF, 8'h04, 8'h00));
      vq.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, IDLE,  8'hFF, 8'h04, 8'h00));

      for (int i = 0; i < vq.size(); i++) step(i, vq[i], 1'b1);

      // ADDR with no command: waits forever, or times out after 4 ADDR cycles.
      step(100, v(0, 1, 0, 0, 8'h00, 8'h00, ADDR, 8'hFF, 8'h04, 8'h00), 1'b1);
      for (int k = 1; k <= 6; k++) begin
`ifdef BUS_TIMEOUT_EN
         step(100 + k, v(0, 0, 0, 0, 8'h00, 8'h00, (k >= 4) ? IDLE : ADDR, 8'hFF, 8'h04, 8'h00),
              1'b1);
`else
         step(100 + k, v(0, 0, 0, 0, 8'h00, 8'h00, ADDR, 8'hFF, 8'h04, 8'h00), 1'b1);
`endif
      end

`ifndef BUS_TIMEOUT_EN
      // A late command still completes normally.
      step(110, v(0, 0, 1, 0, 8'h10, 8'h00, READ, 8'hFF, 8'h10, 8'h00), 1'b1);
      step(111, v(0, 0, 0, 0, 8'h00, 8'h00, DONE, 8'hA5, 8'h10, 8'h00), 1'b1);
      step(112, v(0, 0, 0, 0, 8'h00, 8'h00, IDLE, 8'hA5, 8'h10, 8'h00), 1'b1);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
